// File: rtl/modport_accel.sv
// modport_accel: single-MAC, stride-1, "same"-padded 2-D convolution engine.
// Operands stream in y,x,co,ky,kx,ci order; results leave tagged with (x,y,ch).
module modport_accel #(
    parameter int DATA_WIDTH         = 8,
    parameter int ACCUMULATION_WIDTH = 32,
    parameter int FEATURE_MAP_WIDTH  = 8,
    parameter int FEATURE_MAP_HEIGHT = 8,
    parameter int INPUT_NB_CHANNELS  = 2,
    parameter int OUTPUT_NB_CHANNELS = 4,
    parameter int KERNEL_SIZE        = 3,
    parameter int OUTPUT_SHIFT       = 0,
    localparam int XW = (FEATURE_MAP_WIDTH > 1) ? $clog2(FEATURE_MAP_WIDTH) : 1,
    localparam int YW = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1,
    localparam int CW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  start,
    output logic                  running,
    input  logic [DATA_WIDTH-1:0] a_input,
    input  logic                  a_zero_flag,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [DATA_WIDTH-1:0] b_input,
    input  logic                  b_valid,
    output logic                  b_ready,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic                  output_valid,
    output logic [XW-1:0]         output_x,
    output logic [YW-1:0]         output_y,
    output logic [CW-1:0]         output_ch
);

    localparam int AW      = ACCUMULATION_WIDTH;
    localparam int DW      = DATA_WIDTH;
    localparam int PW      = 2 * DATA_WIDTH;
    localparam int N_STEPS = KERNEL_SIZE * KERNEL_SIZE * INPUT_NB_CHANNELS;
    localparam int SW      = $clog2(N_STEPS + 1);

    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_EMIT} state_t;

    state_t               state_q, state_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [SW-1:0]        step_q, step_d;
    logic [XW-1:0]        x_q, x_d, ox_q, ox_d;
    logic [YW-1:0]        y_q, y_d, oy_q, oy_d;
    logic [CW-1:0]        co_q, co_d, och_q, och_d;
    logic [DW-1:0]        data_q, data_d;
    logic                 valid_q, valid_d;

    logic [DW-1:0]        a_eff;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc_sum, acc_shr;
    logic [DW-1:0]        sat_data;
    logic                 xfer, last_step, last_co, last_x, last_y;

    assign a_eff   = a_zero_flag ? '0 : a_input;
    assign prod    = $signed(a_eff) * $signed(b_input);
    assign acc_sum = acc_q + {{(AW-PW){prod[PW-1]}}, prod};
    assign acc_shr = acc_sum >>> OUTPUT_SHIFT;

    always_comb begin
        sat_data = acc_shr[DW-1:0];
        if (acc_shr > SAT_MAX) sat_data = SAT_MAX[DW-1:0];
        else if (acc_shr < SAT_MIN) sat_data = SAT_MIN[DW-1:0];
    end

    // Both operands move together or not at all.
    assign xfer      = (state_q == S_MAC) && a_valid && b_valid;
    assign last_step = step_q == SW'(N_STEPS - 1);
    assign last_co   = co_q == CW'(OUTPUT_NB_CHANNELS - 1);
    assign last_x    = x_q == XW'(FEATURE_MAP_WIDTH - 1);
    assign last_y    = y_q == YW'(FEATURE_MAP_HEIGHT - 1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        step_d  = step_q;
        x_d     = x_q;
        y_d     = y_q;
        co_d    = co_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ox_d    = ox_q;
        oy_d    = oy_q;
        och_d   = och_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_MAC;
                    acc_d   = '0;
                    step_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                    co_d    = '0;
                end
            end
            S_MAC: begin
                if (xfer) begin
                    acc_d = acc_sum;
                    if (last_step) begin
                        state_d = S_EMIT;
                        step_d  = '0;
                        valid_d = 1'b1;
                        data_d  = sat_data;
                        ox_d    = x_q;
                        oy_d    = y_q;
                        och_d   = co_q;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
            end
            S_EMIT: begin
                acc_d   = '0;
                state_d = (last_co && last_x && last_y) ? S_IDLE : S_MAC;
                if (!last_co) begin
                    co_d = co_q + CW'(1);
                end else begin
                    co_d = '0;
                    if (!last_x) begin
                        x_d = x_q + XW'(1);
                    end else begin
                        x_d = '0;
                        y_d = last_y ? '0 : y_q + YW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            step_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            co_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ox_q    <= '0;
            oy_q    <= '0;
            och_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            x_q     <= x_d;
            y_q     <= y_d;
            co_q    <= co_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            och_q   <= och_d;
        end
    end

    assign running      = state_q != S_IDLE;
    assign a_ready      = xfer;
    assign b_ready      = xfer;
    assign output_data  = data_q;
    assign output_valid = valid_q;
    assign output_x     = ox_q;
    assign output_y     = oy_q;
    assign output_ch    = och_q;

endmodule

// File: tb/tb_modport_accel.sv
// Bench for modport_accel: random maps streamed with optional stalls,
// results compared against a direct software convolution.
module tb_modport_accel;

    localparam int W  = 3;
    localparam int H  = 2;
    localparam int K  = 3;
    localparam int CI = 2;
    localparam int CO = 2;
    localparam int SH = 1;
    localparam int N  = K * K * CI;
    localparam int P  = K / 2;
    localparam int MAP_CYCLES = H * W * CO * (N + 1);

    logic       clk = 1'b0;
    logic       arst_n = 1'b1;
    logic       start = 1'b0;
    logic       running;
    logic [7:0] a_input = '0;
    logic       a_zero_flag = 1'b0;
    logic       a_valid = 1'b0;
    logic       a_ready;
    logic [7:0] b_input = '0;
    logic       b_valid = 1'b0;
    logic       b_ready;
    logic [7:0] output_data;
    logic       output_valid;
    logic [1:0] output_x;
    logic [0:0] output_y;
    logic [0:0] output_ch;

    modport_accel #(
        .DATA_WIDTH(8), .ACCUMULATION_WIDTH(32),
        .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H),
        .INPUT_NB_CHANNELS(CI), .OUTPUT_NB_CHANNELS(CO),
        .KERNEL_SIZE(K), .OUTPUT_SHIFT(SH)
    ) dut (
        .clk(clk), .arst_n(arst_n), .start(start), .running(running),
        .a_input(a_input), .a_zero_flag(a_zero_flag),
        .a_valid(a_valid), .a_ready(a_ready),
        .b_input(b_input), .b_valid(b_valid), .b_ready(b_ready),
        .output_data(output_data), .output_valid(output_valid),
        .output_x(output_x), .output_y(output_y), .output_ch(output_ch)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int ch; int d; } out_t;

    int   checks = 0;
    int   failures = 0;
    int   run_cycles = 0;
    out_t got[$];
    out_t exp_q[$];

    int   act [H][W][CI];
    bit   zm  [H][W][CI];
    int   wt  [CO][K][K][CI];
    logic [7:0] sa[$];
    bit         sz[$];
    logic [7:0] sb[$];

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Handshake rule: ready only in a MAC cycle with both operands valid.
    always @(negedge clk) begin
        logic exp_rdy;
        exp_rdy = running && a_valid && b_valid && !output_valid;
        chk("a_ready", a_ready, exp_rdy);
        chk("b_ready", b_ready, exp_rdy);
        if (running === 1'b1) run_cycles++;
        if (output_valid === 1'b1)
            got.push_back('{int'(output_x), int'(output_y),
                            int'(output_ch), int'($signed(output_data))});
    end

    task automatic setup(input int mode);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                for (int c = 0; c < CI; c++) begin
                    act[y][x][c] = (mode == 0) ? 1 : (mode <= 2) ? 127
                                 : int'($urandom_range(15)) - 8;
                    zm[y][x][c]  = (mode == 3) && ($urandom_range(3) == 0);
                end
        for (int o = 0; o < CO; o++)
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    for (int c = 0; c < CI; c++)
                        wt[o][i][j][c] = (mode == 0) ? 1 : (mode == 1) ? 127
                                       : (mode == 2) ? -128
                                       : int'($urandom_range(15)) - 8;
    endtask

    // Operand stream in loop order plus golden results per output pixel.
    task automatic build();
        sa.delete(); sz.delete(); sb.delete(); exp_q.delete();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                for (int o = 0; o < CO; o++) begin
                    int sum = 0;
                    for (int i = 0; i < K; i++)
                        for (int j = 0; j < K; j++)
                            for (int c = 0; c < CI; c++) begin
                                int iy = y + i - P;
                                int ix = x + j - P;
                                logic [7:0] wb;
                                wb = 8'(wt[o][i][j][c]);
                                sb.push_back(wb);
                                if (iy < 0 || iy >= H || ix < 0 || ix >= W) begin
                                    sa.push_back(8'($urandom));
                                    sz.push_back(1'b1);
                                end else begin
                                    sa.push_back(8'(act[iy][ix][c]));
                                    sz.push_back(zm[iy][ix][c]);
                                    if (!zm[iy][ix][c])
                                        sum += act[iy][ix][c] * wt[o][i][j][c];
                                end
                            end
                    sum = sum >>> SH;
                    if (sum > 127) sum = 127;
                    if (sum < -128) sum = -128;
                    exp_q.push_back('{x, y, o, sum});
                end
    endtask

    task automatic run_map(input int stall, input int limit, input bit pulse);
        int idx = 0;
        int budget = 0;
        bit took;
        got.delete();
        run_cycles = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("running_rise", running, 1);
        while (idx < limit && budget < 20000) begin
            a_valid     = ($urandom_range(99) >= stall);
            b_valid     = ($urandom_range(99) >= stall);
            start       = pulse && (idx == 40);
            a_input     = sa[idx];
            a_zero_flag = sz[idx];
            b_input     = sb[idx];
            @(negedge clk);
            took = a_ready;
            @(posedge clk); #1;
            if (took) idx++;
            budget++;
        end
        start = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        chk("stream_budget", 32'(budget < 20000), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (running && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("running_fall", running, 0);
        @(posedge clk); #1;
    endtask

    task automatic compare(input string tag);
        chk($sformatf("%s_count", tag), got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk($sformatf("%s[%0d].x", tag, i), got[i].x, exp_q[i].x);
            chk($sformatf("%s[%0d].y", tag, i), got[i].y, exp_q[i].y);
            chk($sformatf("%s[%0d].ch", tag, i), got[i].ch, exp_q[i].ch);
            chk($sformatf("%s[%0d].data", tag, i), got[i].d, exp_q[i].d);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_running"}, running, 0);
        chk({tag, "_valid"}, output_valid, 0);
        chk({tag, "_data"}, output_data, 0);
        chk({tag, "_x"}, output_x, 0);
        chk({tag, "_y"}, output_y, 0);
        chk({tag, "_ch"}, output_ch, 0);
    endtask

    initial begin
        arst_n = 1'b1; start = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        chk("reset_a_ready", a_ready, 0);
        @(posedge clk); #1;
        arst_n = 1'b0; start = 1'b0; a_valid = 1'b0; b_valid = 1'b0;

        setup(0); build();
        run_map(0, N * H * W * CO, 1'b0);
        wait_idle();
        compare("ones");
        chk("ones_cycles", run_cycles, MAP_CYCLES);

        setup(1); build();
        run_map(0, N * H * W * CO, 1'b0);
        wait_idle();
        compare("sat_pos");
        chk("sat_pos_d0", got.size() > 0 ? got[0].d : -999, 127);

        setup(2); build();
        run_map(0, N * H * W * CO, 1'b0);
        wait_idle();
        compare("sat_neg");
        chk("sat_neg_d0", got.size() > 0 ? got[0].d : -999, -128);

        setup(3); build();
        run_map(0, N * H * W * CO, 1'b1);
        wait_idle();
        compare("rand");
        chk("rand_cycles", run_cycles, MAP_CYCLES);

        run_map(35, N * H * W * CO, 1'b0);
        wait_idle();
        compare("stall");

        setup(3); build();
        run_map(0, N + 5, 1'b0);
        chk("abort_partial", got.size(), 1);
        arst_n = 1'b1;
        @(posedge clk); #1;
        arst_n = 1'b0;
        check_reset_outputs("abort");
        got.delete();
        repeat (10) @(negedge clk);
        chk("abort_stale", got.size(), 0);
        @(posedge clk); #1;
        run_map(20, N * H * W * CO, 1'b0);
        wait_idle();
        compare("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/modport_accel.md
# modport_accel

Single-MAC 2-D convolution engine: stride 1, "same" padding, square kernel. It computes every output of a FEATURE_MAP_HEIGHT × FEATURE_MAP_WIDTH × OUTPUT_NB_CHANNELS feature map. Activations and weights stream in through two valid/ready ports, and results stream out with their (x, y, ch) coordinates. It sits between the external memory/stimulus side and the result sink, and all sequencing lives inside the block.

## Interface
Parameters:
- DATA_WIDTH, 8, width of activations, weights and output words (signed two's complement)
- ACCUMULATION_WIDTH, 32, signed accumulator width
- FEATURE_MAP_WIDTH, 8, output/input map width (x extent)
- FEATURE_MAP_HEIGHT, 8, output/input map height (y extent)
- INPUT_NB_CHANNELS, 2, input channels
- OUTPUT_NB_CHANNELS, 4, output channels
- KERNEL_SIZE, 3, odd kernel side K
- OUTPUT_SHIFT, 0, arithmetic right shift applied to the accumulator before output saturation

Ports:
- clk  in  1  clock, all logic on rising edge
- arst_n  in  1  reset. One clock; reset is synchronous and active-high. The codebase name is kept: arst_n = 1 resets on the next rising edge.
- start  in  1  start one full-map computation (sampled in IDLE only)
- running  out  1  high from the cycle after start until the last output is emitted
- a_input  in  DATA_WIDTH  activation
- a_zero_flag  in  1  activation is zero or padding; treat a_input as 0
- a_valid  in  1  activation valid
- a_ready  out  1  activation accepted this cycle
- b_input  in  DATA_WIDTH  weight
- b_valid  in  1  weight valid
- b_ready  out  1  weight accepted this cycle
- output_data  out  DATA_WIDTH  signed result
- output_valid  out  1  result valid, one-cycle pulse; no backpressure
- output_x  out  clog2(FEATURE_MAP_WIDTH)  result column
- output_y  out  clog2(FEATURE_MAP_HEIGHT)  result row
- output_ch  out  clog2(OUTPUT_NB_CHANNELS)  result output channel

## Operation
- FSM states IDLE, MAC, EMIT.
- IDLE: running=0, a_ready=b_ready=0. start=1 → MAC, with all counters and the accumulator cleared.
- Loop nest, outermost first: y, x, co, ky, kx, ci. The three inner loops give N = K·K·INPUT_NB_CHANNELS MAC steps per output.
- Padding positions are not skipped. The source supplies them with a_zero_flag=1, and every step consumes one activation and one weight.
- MAC step handshake:
  - a_ready = b_ready = (state==MAC) & a_valid & b_valid, so both operands transfer on the same edge or neither does.
  - On transfer, acc ← acc + (a_zero_flag ? 0 : a_input) × b_input, as a signed product sign-extended to ACCUMULATION_WIDTH.
  - acc wraps modulo 2^ACCUMULATION_WIDTH.
- After the N-th transfer → EMIT.
- EMIT (one cycle):
  - output_valid=1; output_x/y/ch = current x, y, co.
  - output_data = acc >>> OUTPUT_SHIFT, saturated to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - acc cleared. Counters advance co, then x, then y.
  - Next state is MAC, or IDLE after output (H−1, W−1, Cout−1).
- start while running: ignored.
- a_valid/b_valid outside MAC: ignored, no ready.

## Timing
- Reset values: running=0, a_ready=b_ready=0, output_valid=0, output_data=0, output_x=output_y=output_ch=0; state IDLE; acc=0.
- Reset mid-operation aborts immediately: no further outputs, and no result from the partial accumulation.
- start sampled at edge t → running=1 and MAC from cycle t+1. The first possible transfer is at edge t+1.
- Last transfer at edge t → output_valid=1 during cycle t+1.
- With operands always valid, each output takes N+1 cycles. A full map takes H·W·Cout·(N+1) cycles.
- After the final EMIT cycle, running=0 in the next cycle. A new start is accepted from that cycle on.
- Operand stalls (either valid low) freeze counters and acc. There is no partial acceptance.
- Output registers hold their last value when output_valid=0.

## Test plan
- Reset: hold arst_n=1 for 2 cycles with start=1 → all outputs 0, running=0, no ready.
- Scenario A, config W=H=2, K=3, Cin=Cout=1, OUTPUT_SHIFT=0, all activations 1 (padding flagged zero), all weights 1:
  - Outputs are emitted in order (0,0),(1,0),(0,1),(1,1), each with data 4.
  - running falls after the 4th output.
  - 40 cycles start-to-done with no stalls.
- Saturation: Scenario A with activations 127 and weights 127 → output_data=127 each. With weights −128 → −128.
- Stall: randomly drop a_valid and b_valid independently → ready only when both are high; results and order identical to the no-stall run.
- Abort: assert arst_n during the second output's MAC steps, then restart → no stale output; the full correct map is produced.
- Channels and zero flag: Cin=2, Cout=2, with a_zero_flag=1 on nonzero a_input → those operands contribute 0. Outputs are ordered with co fastest, and each matches a software golden convolution.
